// File: rtl/contador_param_if.sv
// Interface: contador_param_if
// Bundles the control inputs and count outputs of contador_param.
// master : the logic that drives the counter (button stage, control).
// slave  : the counter itself.
// Build macro CONTADOR_OVF_STICKY_EN adds the sticky overflow flag ovf_o.
interface contador_param_if #(
  parameter int WIDTH = 8
);
  logic             clear_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic             boton_i;
  logic             dir_i;
  logic [WIDTH-1:0] conta_o;
  logic             tc_o;
`ifdef CONTADOR_OVF_STICKY_EN
  logic             ovf_o;

  modport master (
    output clear_i, load_i, load_val_i, boton_i, dir_i,
    input  conta_o, tc_o, ovf_o
  );

  modport slave (
    input  clear_i, load_i, load_val_i, boton_i, dir_i,
    output conta_o, tc_o, ovf_o
  );
`else
  modport master (
    output clear_i, load_i, load_val_i, boton_i, dir_i,
    input  conta_o, tc_o
  );

  modport slave (
    input  clear_i, load_i, load_val_i, boton_i, dir_i,
    output conta_o, tc_o
  );
`endif
endinterface

// File: rtl/contador_param.sv
// Module: contador_param
// Parametrised event counter fed by the button conditioning stage.
// Counts qualified boton_i events up or down between 0 and MAX_VAL, either
// wrapping or saturating at the limits, with synchronous clear and load
// (clear > load > event > hold) and a registered terminal-count pulse.
// Build macro CONTADOR_OVF_STICKY_EN adds the sticky overflow flag ovf_o,
// set whenever tc_o pulses and cleared only by reset_i or clear_i.
module contador_param #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VAL   = '1,
  parameter int               SATURATE  = 0,
  parameter int               EDGE_MODE = 1
) (
  input logic              clk,
  input logic              reset_i,
  contador_param_if.slave  bus
);

  if (WIDTH < 2) begin : g_bad_width
    $error("contador_param: WIDTH must be at least 2");
  end
  if (MAX_VAL == '0) begin : g_bad_max
    $error("contador_param: MAX_VAL must be at least 1");
  end

  logic             boton_q;
  logic             ev;
  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] conta_q;
  logic [WIDTH-1:0] conta_d;
  logic             tc_q;
  logic             tc_d;

  // Event qualification: a rising edge of boton_i, or simply boton_i high.
  always_comb begin
    if (EDGE_MODE != 0) ev = bus.boton_i & ~boton_q;
    else                ev = bus.boton_i;
  end

  assign at_max       = (conta_q == MAX_VAL);
  assign at_min       = (conta_q == '0);
  assign load_clamped = (bus.load_val_i > MAX_VAL) ? MAX_VAL : bus.load_val_i;

  // Next count and terminal-count pulse: clear > load > event > hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    conta_d = conta_q;
    tc_d    = 1'b0;
    if (bus.clear_i) begin
      conta_d = '0;
    end else if (bus.load_i) begin
      conta_d = load_clamped;
    end else if (ev) begin
      if (bus.dir_i) begin
        if (at_max) begin
          tc_d    = 1'b1;
          conta_d = (SATURATE != 0) ? MAX_VAL : '0;
        end else begin
          conta_d = conta_q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          tc_d    = 1'b1;
          conta_d = (SATURATE != 0) ? '0 : MAX_VAL;
        end else begin
          conta_d = conta_q - WIDTH'(1);
        end
      end
    end
  end

  // Count, pulse and edge-detector registers; reset aborts a count at once.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      conta_q <= '0;
      tc_q    <= 1'b0;
      boton_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      conta_q <= conta_d;
      tc_q    <= tc_d;
      // Tracks boton_i even on clear/load cycles, so a held press is consumed.
      boton_q <= bus.boton_i;
    end
  end

  assign bus.conta_o = conta_q;
  assign bus.tc_o    = tc_q;

`ifdef CONTADOR_OVF_STICKY_EN
  logic ovf_q;

  // Sticky overflow: set with every terminal-count pulse, cleared by clear_i.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      ovf_q <= 1'b0;
    end else if (bus.clear_i) begin
      ovf_q <= 1'b0;
    end else if (tc_d) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_contador_param.sv
// Testbench: tb_contador_param
// Five counters with different WIDTH / MAX_VAL / SATURATE / EDGE_MODE share
// one stimulus stream. Each stimulus cycle pushes the expected outputs of all
// five into a queue; a monitor pops one entry after every clock edge and
// compares. Directed sequences come first, then randomized traffic.
// Define CONTADOR_OVF_STICKY_EN to also check ovf_o.
module tb_contador_param;

  localparam int N = 5;
  localparam int CFG_MAX  [N] = '{255, 9, 9, 150, 15};
  localparam int CFG_SAT  [N] = '{0,   0, 1, 0,   1};
  localparam int CFG_EDGE [N] = '{1,   1, 1, 0,   0};
  localparam int CFG_W    [N] = '{8,   8, 8, 8,   4};

  typedef struct packed {
    logic [N-1:0][7:0] conta;
    logic [N-1:0]      tc;
    logic [N-1:0]      ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       clear, load, boton, dir;
  logic [7:0] load_val;

  logic [7:0] act_conta [N];
  logic       act_tc    [N];
  logic       act_ovf   [N];

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference state: plain integers following the counting rules.
  int m_cnt  [N];
  bit m_prev [N];
  bit m_ovf  [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g8
    contador_param_if #(.WIDTH(8)) bus ();
    assign bus.clear_i    = clear;
    assign bus.load_i     = load;
    assign bus.load_val_i = load_val;
    assign bus.boton_i    = boton;
    assign bus.dir_i      = dir;
    contador_param #(
      .WIDTH(8), .MAX_VAL(8'(CFG_MAX[g])),
      .SATURATE(CFG_SAT[g]), .EDGE_MODE(CFG_EDGE[g])
    ) dut (.clk(clk), .reset_i(reset_i), .bus(bus));
    assign act_conta[g] = bus.conta_o;
    assign act_tc[g]    = bus.tc_o;
`ifdef CONTADOR_OVF_STICKY_EN
    assign act_ovf[g]   = bus.ovf_o;
`else
    assign act_ovf[g]   = 1'b0;
`endif
  end

  contador_param_if #(.WIDTH(4)) bus4 ();
  assign bus4.clear_i    = clear;
  assign bus4.load_i     = load;
  assign bus4.load_val_i = load_val[3:0];
  assign bus4.boton_i    = boton;
  assign bus4.dir_i      = dir;
  contador_param #(
    .WIDTH(4), .MAX_VAL(4'(CFG_MAX[4])),
    .SATURATE(CFG_SAT[4]), .EDGE_MODE(CFG_EDGE[4])
  ) dut4 (.clk(clk), .reset_i(reset_i), .bus(bus4));
  assign act_conta[4] = {4'b0, bus4.conta_o};
  assign act_tc[4]    = bus4.tc_o;
`ifdef CONTADOR_OVF_STICKY_EN
  assign act_ovf[4]   = bus4.ovf_o;
`else
  assign act_ovf[4]   = 1'b0;
`endif

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // Reset the DUTs and the reference model together; pending expectations die.
  task automatic apply_reset();
    clear = 0; load = 0; load_val = '0; boton = 0; dir = 0;
    reset_i = 1'b0;
    q.delete();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_prev[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic check_reset_state(input string name);
    for (int i = 0; i < N; i++) begin
      check({name, "_conta"}, i, act_conta[i], 0);
      check({name, "_tc"}, i, act_tc[i], 0);
`ifdef CONTADOR_OVF_STICKY_EN
      check({name, "_ovf"}, i, act_ovf[i], 0);
`endif
    end
  endtask

  // Drive one cycle of stimulus and push the outputs expected after the edge.
  task automatic step(input bit clr, input bit ld, input int lv, input bit b, input bit d);
    exp_t e;
    @(negedge clk);
    clear = clr; load = ld; load_val = 8'(lv); boton = b; dir = d;
    for (int i = 0; i < N; i++) begin
      int  lvi;
      bit  ev;
      bit  tc;
      lvi = lv % (1 << CFG_W[i]);
      ev  = (CFG_EDGE[i] != 0) ? (b && !m_prev[i]) : b;
      m_prev[i] = b;
      tc = 0;
      if (clr) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end else if (ld) begin
        m_cnt[i] = (lvi > CFG_MAX[i]) ? CFG_MAX[i] : lvi;
      end else if (ev) begin
        if (d) begin
          if (m_cnt[i] == CFG_MAX[i]) begin
            tc = 1;
            if (CFG_SAT[i] == 0) m_cnt[i] = 0;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end else begin
          if (m_cnt[i] == 0) begin
            tc = 1;
            if (CFG_SAT[i] == 0) m_cnt[i] = CFG_MAX[i];
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
      if (tc) m_ovf[i] = 1;
      e.conta[i] = 8'(m_cnt[i]);
      e.tc[i]    = tc;
      e.ovf[i]   = m_ovf[i];
    end
    q.push_back(e);
  endtask

  task automatic pulse(input bit d);
    step(0, 0, 0, 1, d);
    step(0, 0, 0, 0, d);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      for (int i = 0; i < N; i++) begin
        check("conta", i, act_conta[i], e.conta[i]);
        check("tc", i, act_tc[i], e.tc[i]);
`ifdef CONTADOR_OVF_STICKY_EN
        check("ovf", i, act_ovf[i], e.ovf[i]);
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d entries pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    apply_reset();
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset_i = 1'b1;

    // Three separate up pulses.
    repeat (3) pulse(1);

    // Held button for 20 cycles: one event in edge mode, twenty in level mode.
    step(1, 0, 0, 0, 1);
    repeat (20) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // Wrap at the top then back down through zero.
    step(0, 1, 9, 0, 1);
    pulse(1);
    pulse(0);

    // Saturate at the top twice, then at zero once.
    step(0, 1, 9, 0, 1);
    pulse(1);
    pulse(1);
    step(1, 0, 0, 0, 1);
    pulse(0);

    // Load with a simultaneous event (clamped, event dropped), then clear+load.
    step(0, 1, 200, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(1, 1, 77, 0, 0);

    // Sticky flag survives later counts and loads, then clear_i drops it.
    step(0, 1, 255, 0, 1);
    pulse(1);
    pulse(1);
    step(0, 1, 3, 0, 1);
    pulse(0);
    step(1, 0, 0, 0, 1);

    // Asynchronous reset between edges while holding a count.
    step(0, 1, 42, 0, 1);
    @(posedge clk);
    #3;
    apply_reset();
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    reset_i = 1'b1;

    // Randomized traffic, first biased upwards, then downwards.
    for (int k = 0; k < 2000; k++) begin
      bit up_bias;
      up_bias = (k < 1000);
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 19) == 0,
           int'($urandom_range(0, 255)),
           $urandom_range(0, 1) == 1,
           up_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(posedge clk);
    #2;
    check("drain", 0, q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
